// File: rtl/sargantana_icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sargantana_icache_pkg
//  Description : Shared I$ types and constants, including refill MSHR entries.
//  Revision    : 1.0 - initial multi-outstanding refill tracker support
// ============================================================================
package sargantana_icache_pkg;

    localparam int PHY_ADDR_SIZE     = 40;
    localparam int ICACHELINE_SIZE   = 512;
    localparam int ICACHE_INDEX_SIZE = 12;
    localparam int ICACHE_LINE_OFF   = $clog2(ICACHELINE_SIZE / 8);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        PEND   = 2'd1,
        ISSUED = 2'd2
    } ifill_mshr_state_t;

    typedef struct packed {
        ifill_mshr_state_t        state;
        logic                     stale;
        logic [PHY_ADDR_SIZE-1:0] paddr;
    } ifill_mshr_entry_t;

endpackage
`default_nettype wire

// File: rtl/sargantana_icache_ifill_mshr.sv
`default_nettype none
// ============================================================================
//  Module      : sargantana_icache_ifill_mshr
//  Description : I$ refill tracker: merges misses, issues line requests in
//                order, returns fills in order, drops stale fills.
//  Revision    : 1.0 - initial release
// ============================================================================
module sargantana_icache_ifill_mshr
    import sargantana_icache_pkg::*;
#(
    parameter int N_ENTRIES = 2,
    parameter int LINE_W    = ICACHELINE_SIZE,
    parameter int PADDR_W   = PHY_ADDR_SIZE,
    parameter int IDX_W     = ICACHE_INDEX_SIZE
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               miss_valid_i,
    input  logic [PADDR_W-1:0] miss_paddr_i,
    output logic               miss_ready_o,
    input  logic               flush_i,
    input  logic               inv_valid_i,
    input  logic [IDX_W-1:0]   inv_idx_i,
    output logic               ifill_req_valid_o,
    output logic [PADDR_W-1:0] ifill_req_paddr_o,
    input  logic               ifill_ack_i,
    input  logic               ifill_resp_valid_i,
    input  logic [LINE_W-1:0]  ifill_resp_data_i,
    output logic               fill_valid_o,
    output logic [PADDR_W-1:0] fill_paddr_o,
    output logic [LINE_W-1:0]  fill_data_o,
    output logic               busy_o
);

    localparam int c_off   = $clog2(LINE_W / 8);
    localparam int c_ptr_w = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam int c_cnt_w = $clog2(N_ENTRIES + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(N_ENTRIES - 1);

    ifill_mshr_entry_t    r_entries      [N_ENTRIES];
    ifill_mshr_entry_t    w_next_entries [N_ENTRIES];
    logic [c_ptr_w-1:0]   r_alloc_ptr, r_issue_ptr, r_resp_ptr;
    logic [c_ptr_w-1:0]   w_next_alloc_ptr, w_next_issue_ptr, w_next_resp_ptr;
    logic [c_cnt_w-1:0]   r_count, w_next_count, w_pend_cnt;
    logic [N_ENTRIES-1:0] w_inv_hit;
    logic                 w_merge_hit, w_miss_ready, w_alloc, w_ack;
    logic                 w_head_pend, w_resp_fire, w_resp_stale;
    logic [PADDR_W-1:0]   w_miss_line;
    logic                 r_req_valid;
    logic [PADDR_W-1:0]   r_req_paddr;
    logic                 r_fill_valid;
    logic [PADDR_W-1:0]   r_fill_paddr;
    logic [LINE_W-1:0]    r_fill_data;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_last_ptr) ? '0 : ptr + c_ptr_w'(1);
    endfunction

    assign w_miss_line = {miss_paddr_i[PADDR_W-1:c_off], {c_off{1'b0}}};

    always_comb begin
        w_inv_hit   = '0;
        w_merge_hit = 1'b0;
        w_pend_cnt  = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_inv_hit[i] = inv_valid_i && (r_entries[i].state != FREE)
                           && (r_entries[i].paddr[IDX_W-1:0] == inv_idx_i);
            if ((r_entries[i].state != FREE) && !r_entries[i].stale && !w_inv_hit[i]
                && !flush_i && (PADDR_W'(r_entries[i].paddr) == w_miss_line))
                w_merge_hit = 1'b1;
            if (r_entries[i].state == PEND)
                w_pend_cnt = w_pend_cnt + c_cnt_w'(1);
        end
    end

    assign w_miss_ready = !rst_i && !flush_i
                          && ((r_count < c_cnt_w'(N_ENTRIES)) || w_merge_hit);
    assign w_alloc      = miss_valid_i && w_miss_ready && !w_merge_hit;
    assign w_head_pend  = (r_entries[r_issue_ptr].state == PEND);
    assign w_ack        = ifill_ack_i && r_req_valid && w_head_pend;
    assign w_resp_fire  = ifill_resp_valid_i && (r_entries[r_resp_ptr].state == ISSUED);
    assign w_resp_stale = r_entries[r_resp_ptr].stale || w_inv_hit[r_resp_ptr] || flush_i;

    always_comb begin
        w_next_entries = r_entries;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (w_inv_hit[i])
                w_next_entries[i].stale = 1'b1;
            // A flush keeps the presented request alive so valid never drops before ack.
            if (flush_i) begin
                if (r_entries[i].state == ISSUED) begin
                    w_next_entries[i].stale = 1'b1;
                end else if (r_entries[i].state == PEND) begin
                    if (c_ptr_w'(i) == r_issue_ptr) begin
                        w_next_entries[i].stale = 1'b1;
                    end else begin
                        w_next_entries[i].state = FREE;
                        w_next_entries[i].stale = 1'b0;
                    end
                end
            end
        end
        if (w_ack)
            w_next_entries[r_issue_ptr].state = ISSUED;
        if (w_resp_fire) begin
            w_next_entries[r_resp_ptr].state = FREE;
            w_next_entries[r_resp_ptr].stale = 1'b0;
        end
        if (w_alloc) begin
            w_next_entries[r_alloc_ptr].state = PEND;
            w_next_entries[r_alloc_ptr].stale = 1'b0;
            w_next_entries[r_alloc_ptr].paddr = PHY_ADDR_SIZE'(w_miss_line);
        end

        w_next_issue_ptr = w_ack ? ptr_inc(r_issue_ptr) : r_issue_ptr;
        w_next_resp_ptr  = w_resp_fire ? ptr_inc(r_resp_ptr) : r_resp_ptr;
        // Pending entries sit contiguously from the issue pointer, so a flush rewinds alloc.
        if (flush_i)
            w_next_alloc_ptr = w_head_pend ? ptr_inc(r_issue_ptr) : r_issue_ptr;
        else
            w_next_alloc_ptr = w_alloc ? ptr_inc(r_alloc_ptr) : r_alloc_ptr;

        w_next_count = r_count + c_cnt_w'(w_alloc) - c_cnt_w'(w_resp_fire);
        if (flush_i)
            w_next_count = w_next_count - w_pend_cnt + c_cnt_w'(w_head_pend);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_ENTRIES; i++)
                r_entries[i] <= '0;
            r_alloc_ptr  <= '0;
            r_issue_ptr  <= '0;
            r_resp_ptr   <= '0;
            r_count      <= '0;
            r_req_valid  <= 1'b0;
            r_req_paddr  <= '0;
            r_fill_valid <= 1'b0;
            r_fill_paddr <= '0;
            r_fill_data  <= '0;
        end else begin
            r_entries   <= w_next_entries;
            r_alloc_ptr <= w_next_alloc_ptr;
            r_issue_ptr <= w_next_issue_ptr;
            r_resp_ptr  <= w_next_resp_ptr;
            r_count     <= w_next_count;
            r_req_valid <= (w_next_entries[w_next_issue_ptr].state == PEND);
            r_req_paddr <= (w_next_entries[w_next_issue_ptr].state == PEND)
                           ? PADDR_W'(w_next_entries[w_next_issue_ptr].paddr) : '0;
            r_fill_valid <= w_resp_fire && !w_resp_stale;
            if (w_resp_fire && !w_resp_stale) begin
                r_fill_paddr <= PADDR_W'(r_entries[r_resp_ptr].paddr);
                r_fill_data  <= ifill_resp_data_i;
            end
        end
    end

    assign miss_ready_o      = w_miss_ready;
    assign ifill_req_valid_o = r_req_valid;
    assign ifill_req_paddr_o = r_req_paddr;
    assign fill_valid_o      = r_fill_valid;
    assign fill_paddr_o      = r_fill_paddr;
    assign fill_data_o       = r_fill_data;
    assign busy_o            = (r_count != '0);

`ifndef SYNTHESIS
    // Responses still in flight when reset hit are tolerated until the next ack.
    logic r_post_rst;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_post_rst <= 1'b1;
        else if (w_ack)
            r_post_rst <= 1'b0;
    end

    a_resp_needs_issued : assert property (@(posedge clk_i) disable iff (rst_i)
        (ifill_resp_valid_i && !r_post_rst) |-> (r_entries[r_resp_ptr].state == ISSUED));
`endif

endmodule
`default_nettype wire

// File: doc/sargantana_icache_ifill_mshr.md
Name: sargantana_icache_ifill_mshr

Overview:
- Parametrised I$ refill tracker with multiple outstanding misses; sits between the I$ controller (miss side) and the IFILL memory interface.
- Allocates one entry per distinct missed line, merges duplicate misses, issues line-aligned IFILL requests in order and returns fills in order.
- Suppresses fills made stale by invalidation or flush, so the single-miss controller can move to N outstanding lines.

Parameters:
N_ENTRIES, 2, outstanding line fills (power of two, >=1)
LINE_W, 512, cache line bits (256 or 512)
PADDR_W, 40, physical address width (drac_pkg::PHY_ADDR_SIZE)
IDX_W, 12, invalidation index width (ICACHE_INDEX_SIZE)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, asynchronous, active-high
miss_valid_i  in  1  controller presents a miss
miss_paddr_i  in  PADDR_W  missed physical address (any byte offset)
miss_ready_o  out  1  miss accepted when valid&ready
flush_i  in  1  drop/mark stale all outstanding work
inv_valid_i  in  1  invalidation strobe
inv_idx_i  in  IDX_W  index being invalidated
ifill_req_valid_o  out  1  IFILL request valid
ifill_req_paddr_o  out  PADDR_W  line-aligned request address
ifill_ack_i  in  1  request accepted by memory side
ifill_resp_valid_i  in  1  refill data valid (in ack order)
ifill_resp_data_i  in  LINE_W  full line
fill_valid_o  out  1  write line into I$ (one cycle)
fill_paddr_o  out  PADDR_W  line-aligned address of fill
fill_data_o  out  LINE_W  line data
busy_o  out  1  any entry non-free

Behaviour:
- OFF = log2(LINE_W/8). Line address = paddr with OFF LSBs cleared. Index of an entry = paddr[IDX_W-1:0].
- Per-entry state: FREE, PEND (allocated, not acked), ISSUED (acked, awaiting data). Per-entry stale bit.
- Three circular pointers: alloc, issue, resp. Each wraps N_ENTRIES-1 -> 0. Count register 0..N_ENTRIES.

Reset:
- All entries FREE, stale=0, pointers/count=0.
- All outputs 0 while rst_i is high, including miss_ready_o.
- Reset mid-transaction discards everything. A response arriving after reset with no ISSUED entry is ignored.

Accept:
- miss_ready_o = !rst_i && (count<N_ENTRIES || merge_hit).
- merge_hit: a non-FREE, non-stale entry has an equal line address and is not hit by this cycle's inv/flush. A merge accepts with no allocation.
- Otherwise the miss allocates at the alloc pointer: PEND, stale=0, effective next edge.

Issue:
- ifill_req_valid_o is registered: high while entry[issue] is PEND.
- The address is held stable until ifill_ack_i. On ack the entry becomes ISSUED and issue advances.
- Next request is earliest the cycle after ack. A miss accepted at T gives request valid at T+1.

Response:
- On ifill_resp_valid_i, entry[resp] must be ISSUED. Entry is freed, resp advances, count decrements.
- fill_valid_o=1 at R+1 with the registered address/data, only if stale=0. A stale response is consumed silently (fill_valid_o=0).
- A freed slot is visible to miss_ready_o from R+1. There is no same-cycle free+alloc bypass when full.

Invalidation:
- Every non-FREE entry whose index equals inv_idx_i sets stale at the next edge.
- Same-cycle response for that entry: stale wins, fill suppressed.
- Same-cycle allocation with a matching index: the new entry is NOT stale.

Flush:
- ISSUED entries become stale.
- PEND entries are freed, except the entry currently driving ifill_req_valid_o. That entry stays PEND and stale until acked (valid-stability rule).
- Pointers/count are adjusted accordingly. A miss on the flush cycle is not accepted (miss_ready_o forced 0).

Other rules:
- Count: +1 on alloc, -1 on response/free. Simultaneous alloc+response leaves count unchanged.
- busy_o = count!=0.
- A response with no ISSUED entry is a protocol error: SVA assertion, and the state is left unchanged.

Decomposition:
- Add to sargantana_icache_pkg: enum ifill_mshr_state_t {FREE, PEND, ISSUED}.
- Add struct ifill_mshr_entry_t {state, stale, line paddr}.
- Add localparam ICACHE_LINE_OFF = $clog2(ICACHELINE_SIZE/8).
- Single module; entry array inline. No sub-module needed.

Test Plan:
- Single miss: miss paddr 0x8000_0044 (LINE_W=512) -> req paddr 0x8000_0040 next cycle; ack, resp data D -> fill_valid_o=1, fill_paddr_o=0x8000_0040, fill_data_o=D, busy_o=0 one cycle after.
- Merge/full: misses 0x1000, 0x1008, 0x2000, 0x3000 on consecutive cycles (N=2) -> 0x1008 merged; 0x3000 stalls (miss_ready_o=0) until one cycle after the first response; requests appear in order 0x1000, 0x2000, 0x3000.
- Invalidate: issue 0x1040 (idx 0x040), inv_idx_i=0x040 before resp -> response consumed, fill_valid_o stays 0, entry freed; same-cycle inv+resp also suppressed.
- Flush: 2 PEND entries, the first presented unacked, flush_i -> first stays valid until ack and its response is not filled; second is never requested; count returns to 0.
- Wrap-around: 10 sequential distinct misses with random ack/resp delays 0-5 cycles -> fills in order, pointers wrap, no loss or duplication.
- Async reset mid-ISSUED: rst_i pulse between clock edges -> outputs 0 immediately, later stray resp ignored, new miss works normally.
